alu_split: RTL and testbench



---
 rtl/alu_split_pkg.sv | 37 +++
 rtl/alu_split_onehot_dec.sv | 22 ++
 rtl/alu_split.sv | 79 +++++++
 tb/tb_alu_split.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alu_split_pkg.sv
`default_nettype none
// ============================================================================
// Package   : alu_pkg
// Purpose   : Shared widths, field types, instruction layout and opcode names
//             for the ALU front-end field splitter and the ALU itself.
// Revision  : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int CTRL_W = 3;
  localparam int OPER_W = 6;
  localparam int DATA_W = CTRL_W + 2 * OPER_W;

  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [OPER_W-1:0] oper_t;

  // Packed instruction word, MSB first: {control, a, b}
  typedef struct packed {
    ctrl_t control;
    oper_t a;
    oper_t b;
  } instr_t;

  // Opcode names shared with the ALU; the encoding is the decoder index
  typedef enum logic [CTRL_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_split_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module    : onehot_dec
// Purpose   : Parameterised N-to-2**N binary to one-hot decoder.
// Revision  : 1.0 - initial release
// ============================================================================
module onehot_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]      i_bin,
  output logic [(2**N)-1:0] o_onehot
);

  localparam int M = 2 ** N;

  // Exactly one output bit set, at the index given by the binary input
  always_comb begin
    o_onehot = {{(M-1){1'b0}}, 1'b1} << i_bin;
  end

endmodule : onehot_dec
`default_nettype wire

// File: rtl/alu_split.sv
`default_nettype none
// ============================================================================
// Module    : alu_split
// Purpose   : Registered splitter of a packed {control, A, B} instruction word
//             with a valid flag at matching latency and a one-hot opcode
//             decode for the ALU.
// Revision  : 1.0 - initial release
// ============================================================================
module alu_split #(
  parameter  int CTRL_W = alu_pkg::CTRL_W,
  parameter  int OPER_W = alu_pkg::OPER_W,
  localparam int DATA_W = CTRL_W + 2 * OPER_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      data,
  input  logic                   data_valid,
  output logic [CTRL_W-1:0]      control,
  output logic [OPER_W-1:0]      A,
  output logic [OPER_W-1:0]      B,
  output logic                   out_valid,
  output logic [(2**CTRL_W)-1:0] op_sel
);

  import alu_pkg::*;

  logic [CTRL_W-1:0] w_ctrl;
  logic [OPER_W-1:0] w_a;
  logic [OPER_W-1:0] w_b;

  logic [CTRL_W-1:0] r_control;
  logic [OPER_W-1:0] r_a;
  logic [OPER_W-1:0] r_b;
  logic              r_out_valid;

  // At the shared widths the word is unpacked through the common layout
  // type so the ALU and this block cannot disagree on field order; any
  // other width pair falls back to the same map expressed by slicing.
  if (CTRL_W == alu_pkg::CTRL_W && OPER_W == alu_pkg::OPER_W) begin : g_pkg_layout
    instr_t w_instr;
    assign w_instr = instr_t'(data);
    assign w_ctrl  = w_instr.control;
    assign w_a     = w_instr.a;
    assign w_b     = w_instr.b;
  end else begin : g_param_layout
    assign w_ctrl = data[DATA_W-1 -: CTRL_W];
    assign w_a    = data[2*OPER_W-1 : OPER_W];
    assign w_b    = data[OPER_W-1 : 0];
  end

  // Free-running capture: fields load every edge regardless of valid
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_control   <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_control   <= w_ctrl;
      r_a         <= w_a;
      r_b         <= w_b;
      r_out_valid <= data_valid;
    end
  end

  onehot_dec #(
    .N (CTRL_W)
  ) u_onehot_dec (
    .i_bin    (r_control),
    .o_onehot (op_sel)
  );

  assign control   = r_control;
  assign A         = r_a;
  assign B         = r_b;
  assign out_valid = r_out_valid;

endmodule : alu_split
`default_nettype wire

// File: tb/tb_alu_split.sv
`default_nettype none
// ============================================================================
// Module    : tb_alu_split
// Purpose   : Directed and streamed self-checking bench for alu_split.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_alu_split;

  logic        clk;
  logic        reset_n;
  logic [14:0] data;
  logic        data_valid;
  logic [2:0]  control;
  logic [5:0]  A;
  logic [5:0]  B;
  logic        out_valid;
  logic [7:0]  op_sel;

  int tests_run;
  int tests_failed;

  alu_split dut (
    .clock      (clk),
    .reset_n    (reset_n),
    .data       (data),
    .data_valid (data_valid),
    .control    (control),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .op_sel     (op_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed {control, A, B, out_valid, op_sel} packed for comparison
  function automatic logic [23:0] obs();
    return {control, A, B, out_valid, op_sel};
  endfunction

  task automatic drive(input logic rn, input logic [14:0] d, input logic v);
    @(negedge clk);
    reset_n    = rn;
    data       = d;
    data_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 15'h0000, 1'b0);
    drive(1'b0, 15'h7FFF, 1'b1);
    tests_run++;
    if (obs() !== {3'd0, 6'h00, 6'h00, 1'b0, 8'h01}) begin
      tests_failed++;
      $display("FAIL reset_state got=%h exp=%h", obs(), {3'd0, 6'h00, 6'h00, 1'b0, 8'h01});
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 15'b101_110011_001100, 1'b1);
    tests_run++;
    if (obs() !== {3'd5, 6'h33, 6'h0C, 1'b1, 8'h20}) begin
      tests_failed++;
      $display("FAIL basic_split got=%h exp=%h", obs(), {3'd5, 6'h33, 6'h0C, 1'b1, 8'h20});
    end
  endtask

  task automatic test_boundary();
    drive(1'b1, 15'h7FFF, 1'b1);
    tests_run++;
    if (obs() !== {3'd7, 6'h3F, 6'h3F, 1'b1, 8'h80}) begin
      tests_failed++;
      $display("FAIL all_ones got=%h exp=%h", obs(), {3'd7, 6'h3F, 6'h3F, 1'b1, 8'h80});
    end
    drive(1'b1, 15'h0000, 1'b1);
    tests_run++;
    if (obs() !== {3'd0, 6'h00, 6'h00, 1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL all_zeros got=%h exp=%h", obs(), {3'd0, 6'h00, 6'h00, 1'b1, 8'h01});
    end
    // Single-field walking patterns: only one field non-zero at a time
    drive(1'b1, 15'b011_000000_000000, 1'b1);
    tests_run++;
    if (obs() !== {3'd3, 6'h00, 6'h00, 1'b1, 8'h08}) begin
      tests_failed++;
      $display("FAIL ctrl_only got=%h exp=%h", obs(), {3'd3, 6'h00, 6'h00, 1'b1, 8'h08});
    end
    drive(1'b1, 15'b000_100001_000000, 1'b1);
    tests_run++;
    if (obs() !== {3'd0, 6'h21, 6'h00, 1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL a_only got=%h exp=%h", obs(), {3'd0, 6'h21, 6'h00, 1'b1, 8'h01});
    end
    drive(1'b1, 15'b000_000000_100001, 1'b1);
    tests_run++;
    if (obs() !== {3'd0, 6'h00, 6'h21, 1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL b_only got=%h exp=%h", obs(), {3'd0, 6'h00, 6'h21, 1'b1, 8'h01});
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 15'h1234, 1'b1);
    drive(1'b0, 15'h5555, 1'b1);
    tests_run++;
    if (obs() !== {3'd0, 6'h00, 6'h00, 1'b0, 8'h01}) begin
      tests_failed++;
      $display("FAIL reset_overrides got=%h exp=%h", obs(), {3'd0, 6'h00, 6'h00, 1'b0, 8'h01});
    end
    drive(1'b0, 15'h5555, 1'b1);
    tests_run++;
    if (obs() !== {3'd0, 6'h00, 6'h00, 1'b0, 8'h01}) begin
      tests_failed++;
      $display("FAIL reset_hold got=%h exp=%h", obs(), {3'd0, 6'h00, 6'h00, 1'b0, 8'h01});
    end
    drive(1'b1, 15'h5555, 1'b1);
    tests_run++;
    if (obs() !== {3'd5, 6'h15, 6'h15, 1'b1, 8'h20}) begin
      tests_failed++;
      $display("FAIL reset_release got=%h exp=%h", obs(), {3'd5, 6'h15, 6'h15, 1'b1, 8'h20});
    end
  endtask

  task automatic test_invalid();
    drive(1'b1, 15'h1234, 1'b0);
    tests_run++;
    if (obs() !== {3'd1, 6'h08, 6'h34, 1'b0, 8'h02}) begin
      tests_failed++;
      $display("FAIL invalid_word got=%h exp=%h", obs(), {3'd1, 6'h08, 6'h34, 1'b0, 8'h02});
    end
    drive(1'b1, 15'h6ABC, 1'b1);
    tests_run++;
    if (obs() !== {3'd6, 6'h2A, 6'h3C, 1'b1, 8'h40}) begin
      tests_failed++;
      $display("FAIL valid_return got=%h exp=%h", obs(), {3'd6, 6'h2A, 6'h3C, 1'b1, 8'h40});
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] w;
    logic        v;
    logic [2:0]  e_ctrl;
    logic [7:0]  e_sel;
    int          errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      w      = 15'($random);
      v      = 1'($random);
      drive(1'b1, w, v);
      e_ctrl = w[14:12];
      e_sel  = 8'd1 << e_ctrl;
      tests_run++;
      if ({control, A, B, out_valid} !== {w, v}) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL stream_fields[%0d] got=%h exp=%h", i, {control, A, B, out_valid}, {w, v});
        errs++;
      end
      tests_run++;
      if (op_sel !== e_sel || $countones(op_sel) != 1) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL stream_op_sel[%0d] got=%h exp=%h", i, op_sel, e_sel);
        errs++;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    data         = '0;
    data_valid   = 1'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_reset_midstream();
    test_invalid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_alu_split
`default_nettype wire
